autoplay_sequencer: RTL and testbench

Playback sequencer downstream of the internal memory unit. Fetches one stored music word at a time through the unit's read handshake and decodes it into pitch and length. Holds each pitch on `note_out`/`note_valid` for the encoded length, with a short silent articulation gap, then advances. Drives the buzzer tone generator in autoplay, learning and game modes.

---
 rtl/autoplay_sequencer.sv | 160 ++++++++++++++++
 tb/tb_autoplay_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/autoplay_sequencer.sv
// Fetches music words from the memory unit and plays each pitch for its encoded length.
// Define AUTOPLAY_SEQ_LOOP_EN to repeat the song until stop instead of ending in DONE.
module autoplay_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_DEPTH_BIT = 8,
    parameter int TICK_CYCLES   = 25_000_000,
    parameter int GAP_CYCLES    = 2_500_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic [MAX_DEPTH_BIT-1:0] song_len,
    output logic                     mem_read_en,
    output logic                     mem_read_rst,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    input  logic                     mem_ready,
    output logic [4:0]               note_out,
    output logic                     note_valid,
    output logic [MAX_DEPTH_BIT-1:0] note_idx,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        S_IDLE, S_REWIND, S_FETCH, S_WAIT, S_PLAY, S_GAP, S_DONE
    } state_e;

    localparam logic [31:0] TICK_W = 32'(TICK_CYCLES);
    localparam logic [31:0] GAP_W  = 32'(GAP_CYCLES);

    state_e                   state_q, state_d;
    logic [31:0]              cnt_q, cnt_d;
    logic [4:0]               pitch_q, pitch_d;
    logic [2:0]               lenc_q, lenc_d;
    logic [MAX_DEPTH_BIT-1:0] slen_q, slen_d;
    logic [MAX_DEPTH_BIT-1:0] idx_q, idx_d;
    logic [MAX_DEPTH_BIT:0]   idx_nx;
    logic [31:0]              play_lim;
    logic rd_en_q, rd_en_d, rd_rst_q, rd_rst_d;
    logic valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [4:0] note_q, note_d;

    assign play_lim = (32'(lenc_q) + 32'd1) * TICK_W - GAP_W;
    assign idx_nx   = {1'b0, idx_q} + (MAX_DEPTH_BIT+1)'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pitch_d = pitch_q;
        lenc_d  = lenc_q;
        slen_d  = slen_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_REWIND;
                    idx_d   = '0;
                end
            end
            S_REWIND: begin
                slen_d  = song_len;
                state_d = (song_len == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (mem_ready) begin
                    pitch_d = mem_data[4:0];
                    lenc_d  = mem_data[7:5];
                    cnt_d   = '0;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!pause) begin
                    if (cnt_q == play_lim - 32'd1) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            S_GAP: begin
                if (!pause) begin
                    if (cnt_q == GAP_W - 32'd1) begin
                        cnt_d = '0;
                        if (idx_nx < {1'b0, slen_q}) begin
                            idx_d   = idx_nx[MAX_DEPTH_BIT-1:0];
                            state_d = S_FETCH;
                        end else begin
`ifdef AUTOPLAY_SEQ_LOOP_EN
                            idx_d   = '0;
                            state_d = S_REWIND;
`else
                            state_d = S_DONE;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (stop && state_q != S_IDLE) state_d = S_IDLE;

        // Outputs are derived from the next state so they line up with it once registered
        rd_rst_d = (state_d == S_REWIND) || (stop && state_q != S_IDLE);
        rd_en_d  = (state_d == S_FETCH);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE) ||
                   (state_q == S_GAP && state_d == S_REWIND);
        valid_d  = (state_d == S_PLAY) && (pitch_d != 5'd0) && !pause;
        note_d   = 5'd0;
        if (state_d == S_PLAY)     note_d = pitch_d;
        else if (state_d == S_GAP) note_d = pitch_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pitch_q  <= '0;
            lenc_q   <= '0;
            slen_q   <= '0;
            idx_q    <= '0;
            rd_en_q  <= 1'b0;
            rd_rst_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            note_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pitch_q  <= pitch_d;
            lenc_q   <= lenc_d;
            slen_q   <= slen_d;
            idx_q    <= idx_d;
            rd_en_q  <= rd_en_d;
            rd_rst_q <= rd_rst_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            note_q   <= note_d;
        end
    end

    assign mem_read_en  = rd_en_q;
    assign mem_read_rst = rd_rst_q;
    assign note_out     = note_q;
    assign note_valid   = valid_q;
    assign note_idx     = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_autoplay_sequencer.sv
// Bench for autoplay_sequencer: memory model with variable latency and note-level reference.
// Build with AUTOPLAY_SEQ_LOOP_EN defined to exercise the looping variant.
module tb_autoplay_sequencer;
    localparam int T = 10;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause;
    logic [7:0] song_len, mem_data;
    logic       mem_ready, mem_read_en, mem_read_rst;
    logic [4:0] note_out;
    logic       note_valid, busy, done;
    logic [7:0] note_idx;

    autoplay_sequencer #(
        .DATA_WIDTH(8), .MAX_DEPTH_BIT(8), .TICK_CYCLES(T), .GAP_CYCLES(G)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .song_len(song_len), .mem_read_en(mem_read_en),
        .mem_read_rst(mem_read_rst), .mem_data(mem_data),
        .mem_ready(mem_ready), .note_out(note_out), .note_valid(note_valid),
        .note_idx(note_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] mem [16];
    int lat, cd, ptr, cyc;
    int vcnt [16];
    int pseen [16];
    int trise [16];
    int rden [$];
    int dcnt, dtime, rstcnt, maxidx, badpitch;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear();
        for (int i = 0; i < 16; i++) begin
            vcnt[i] = 0; pseen[i] = 0; trise[i] = -1;
        end
        rden.delete();
        dcnt = 0; dtime = -1; rstcnt = 0; maxidx = 0; badpitch = 0;
        cd = 0; ptr = 0;
    endtask

    // Advance one clock; memory answers, then outputs are observed at the falling edge
    task automatic step();
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mem_ready = 1'b1;
                mem_data  = mem[ptr % 16];
                ptr++;
            end
        end
        @(negedge clk);
        cyc++;
        if (note_valid) begin
            if (vcnt[note_idx[3:0]] == 0) trise[note_idx[3:0]] = cyc;
            vcnt[note_idx[3:0]]++;
            pseen[note_idx[3:0]] = int'(note_out);
            if (note_out == 5'd0) badpitch++;
        end
        if (done) begin dcnt++; dtime = cyc; end
        if (mem_read_en) begin rden.push_back(cyc); cd = lat; end
        if (mem_read_rst) begin rstcnt++; ptr = 0; end
        if (int'(note_idx) > maxidx) maxidx = int'(note_idx);
    endtask

    task automatic run_to_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin step(); n++; end
        chk("idle_reached", int'(busy), 0);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!note_valid && n < budget) begin step(); n++; end
        chk("valid_reached", int'(note_valid), 1);
    endtask

    task automatic kick(input int n, input int l);
        clear();
        lat = l;
        song_len = 8'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Reference: each note occupies (len+1)*T cycles of PLAY+GAP, plus fetch overhead
    task automatic check_song(input string tag, input int n, input int extra0);
        int p, ln, span, nxt;
        chk({tag, "_fetches"}, rden.size(), n);
        chk({tag, "_done"}, dcnt, 1);
        chk({tag, "_maxidx"}, maxidx, n - 1);
        chk({tag, "_rewinds"}, rstcnt, 1);
        chk({tag, "_rest_valid"}, badpitch, 0);
        for (int k = 0; k < n; k++) begin
            p  = int'(mem[k][4:0]);
            ln = int'(mem[k][7:5]);
            chk({tag, "_vcnt"}, vcnt[k], (p != 0) ? (ln + 1) * T - G : 0);
            span = lat + 1 + (ln + 1) * T + ((k == 0) ? extra0 : 0);
            if (k < rden.size()) begin
                if (p != 0) begin
                    chk({tag, "_pitch"}, pseen[k], p);
                    chk({tag, "_rise"}, trise[k] - rden[k], lat + 1);
                end
                nxt = (k + 1 < n) ? ((k + 1 < rden.size()) ? rden[k+1] : -1)
                                  : dtime;
                chk({tag, "_span"}, nxt - rden[k], span);
            end
        end
    endtask

    initial begin
        int n, cnt;
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        song_len = '0; mem_data = '0; mem_ready = 1'b0;
        lat = 1; cyc = 0;
        clear();
        step(); step();
        chk("reset_outputs",
            int'({mem_read_en, mem_read_rst, note_out, note_valid,
                  note_idx, busy, done}), 0);
        rst = 1'b0;
        step();
        chk("idle_busy", int'(busy), 0);

`ifndef AUTOPLAY_SEQ_LOOP_EN
        mem[0] = 8'h23; mem[1] = 8'h05;
        kick(2, 1);
        run_to_idle(2000);
        check_song("basic", 2, 0);
        chk("basic_pitch0", pseen[0], 3);
        chk("basic_vcnt1", vcnt[1], 8);

        clear();
        song_len = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("empty_c1_rst", int'(mem_read_rst), 1);
        chk("empty_c1_busy", int'(busy), 1);
        step();
        chk("empty_c2_done", int'(done), 1);
        step();
        chk("empty_c3_busy", int'(busy), 0);
        chk("empty_no_fetch", rden.size(), 0);
        chk("empty_done_cnt", dcnt, 1);

        mem[0] = 8'h40; mem[1] = 8'h21;
        kick(2, 2);
        run_to_idle(2000);
        check_song("rest", 2, 0);

        mem[0] = 8'h23; mem[1] = 8'h05;
        kick(2, 1);
        wait_valid(100);
        for (int i = 0; i < 3; i++) step();
        pause = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin step(); cnt += int'(note_valid); end
        pause = 1'b0;
        chk("pause_silent", cnt, 0);
        run_to_idle(2000);
        check_song("pause", 2, 15);

        kick(2, 1);
        wait_valid(100);
        for (int i = 0; i < 7; i++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_valid", int'(note_valid), 0);
        chk("stop_note", int'(note_out), 0);
        chk("stop_rst", int'(mem_read_rst), 1);
        chk("stop_busy", int'(busy), 0);
        step();
        chk("stop_busy2", int'(busy), 0);
        chk("stop_no_done", dcnt, 0);
        chk("stop_rewinds", rstcnt, 2);

        clear();
        song_len = 8'd2;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        step();
        chk("startstop_busy", int'(busy), 0);
        chk("startstop_rst", rstcnt, 0);

        kick(2, 1);
        wait_valid(100);
        #1 rst = 1'b1;
        #1;
        chk("async_rst",
            int'({mem_read_en, mem_read_rst, note_out, note_valid,
                  note_idx, busy, done}), 0);
        rst = 1'b0;
        step();
        chk("async_rst_idle", int'(busy), 0);

        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < 16; k++) mem[k] = 8'($urandom);
            kick(n, int'($urandom_range(1, 3)));
            run_to_idle(3000);
            check_song("rand", n, 0);
        end
`else
        mem[0] = 8'h05;
        kick(1, 1);
        for (int i = 0; i < 39; i++) step();
        chk("loop_done_cnt", dcnt, 3);
        chk("loop_vcnt", vcnt[0], 24);
        chk("loop_rewinds", rstcnt, 4);
        chk("loop_busy", int'(busy), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("loop_stop_busy", int'(busy), 0);
        chk("loop_stop_valid", int'(note_valid), 0);
        cnt = dcnt;
        for (int i = 0; i < 20; i++) step();
        chk("loop_stays_idle", int'(busy), 0);
        chk("loop_no_more_done", dcnt, cnt);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
